// File: rtl/result_display_scanner.sv
// Result display stage: double-dabble / hex conversion of an 8-bit result,
// scanned onto four digits of a shared active-low seven-segment bus.
module result_display_scanner #(
  parameter int TICK_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       hex_mode,
  input  logic       signed_mode,
  output logic       busy,
  output logic [6:0] segments,
  output logic [7:0] anodes
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] MINUS = 5'h11;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state;
  logic [7:0]  mag;
  logic [7:0]  hexval;
  logic        neg;
  logic        hexm;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [2:0]  cnt;
  logic [4:0]  disp [4];
  logic [TW-1:0] tick;
  logic [1:0]  idx;

  assign busy = (state != IDLE);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'h00:   glyph = 7'b0000001;
      5'h01:   glyph = 7'b1001111;
      5'h02:   glyph = 7'b0010010;
      5'h03:   glyph = 7'b0000110;
      5'h04:   glyph = 7'b1001100;
      5'h05:   glyph = 7'b0100100;
      5'h06:   glyph = 7'b0100000;
      5'h07:   glyph = 7'b0001111;
      5'h08:   glyph = 7'b0000000;
      5'h09:   glyph = 7'b0000100;
      5'h0A:   glyph = 7'b0001000;
      5'h0B:   glyph = 7'b1100000;
      5'h0C:   glyph = 7'b0110001;
      5'h0D:   glyph = 7'b1000010;
      5'h0E:   glyph = 7'b0110000;
      5'h0F:   glyph = 7'b0111000;
      MINUS:   glyph = 7'b1111110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      mag     <= '0;
      hexval  <= '0;
      neg     <= 1'b0;
      hexm    <= 1'b0;
      bcd     <= '0;
      cnt     <= '0;
      disp[0] <= 5'h00;
      disp[1] <= BLANK;
      disp[2] <= BLANK;
      disp[3] <= BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            hexval <= value;
            hexm   <= hex_mode;
            neg    <= signed_mode && value[7];
            mag    <= (signed_mode && value[7]) ? (~value + 8'd1) : value;
            bcd    <= '0;
            cnt    <= '0;
            state  <= hex_mode ? COMMIT : SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {adj[10:0], mag[7]};
          mag <= {mag[6:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          // Whole digit set is swapped in one edge so the scan never tears.
          if (hexm) begin
            disp[0] <= {1'b0, hexval[3:0]};
            disp[1] <= {1'b0, hexval[7:4]};
            disp[2] <= BLANK;
            disp[3] <= BLANK;
          end else begin
            disp[0] <= {1'b0, bcd[3:0]};
            disp[1] <= (bcd[11:4] == 8'd0) ? BLANK : {1'b0, bcd[7:4]};
            disp[2] <= (bcd[11:8] == 4'd0) ? BLANK : {1'b0, bcd[11:8]};
            disp[3] <= neg ? MINUS : BLANK;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick     <= '0;
      idx      <= '0;
      anodes   <= 8'hFF;
      segments <= 7'h7F;
    end else begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        idx  <= idx + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end
      anodes   <= {4'hF, ~(4'b0001 << idx)};
      segments <= glyph(disp[idx]);
    end
  end

endmodule

// File: tb/tb_result_display_scanner.sv
// Bench for result_display_scanner: scan timing, busy length and
// decoded digits against an arithmetic reference model.
module tb_result_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = '0;
  logic       load = 1'b0;
  logic       hex_mode = 1'b0;
  logic       signed_mode = 1'b0;
  logic       busy;
  logic [6:0] segments;
  logic [7:0] anodes;

  int n_checks = 0;
  int n_pass = 0;

  logic [27:0] sb [$];

  result_display_scanner #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .hex_mode(hex_mode), .signed_mode(signed_mode),
    .busy(busy), .segments(segments), .anodes(anodes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[d];
  endfunction

  // Reference model: {d3,d2,d1,d0} glyphs via plain integer arithmetic.
  function automatic logic [27:0] model(input logic [7:0] v,
                                        input logic h, input logic s);
    logic [6:0] d0, d1, d2, d3;
    int m, hu, te, on;
    bit ng;
    if (h) begin
      d0 = seg_of(int'(v[3:0]));
      d1 = seg_of(int'(v[7:4]));
      d2 = 7'h7F;
      d3 = 7'h7F;
    end else begin
      ng = s && v[7];
      m  = ng ? 256 - int'(v) : int'(v);
      hu = m / 100;
      te = (m / 10) % 10;
      on = m % 10;
      d0 = seg_of(on);
      d1 = (hu != 0 || te != 0) ? seg_of(te) : 7'h7F;
      d2 = (hu != 0) ? seg_of(hu) : 7'h7F;
      d3 = ng ? 7'b1111110 : 7'h7F;
    end
    return {d3, d2, d1, d0};
  endfunction

  task automatic scan_compare(input string tag);
    logic [6:0] got [4];
    logic [27:0] exp;
    for (int i = 0; i < 4; i++) got[i] = 7'h00;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (anodes)
        8'hFE: got[0] = segments;
        8'hFD: got[1] = segments;
        8'hFB: got[2] = segments;
        8'hF7: got[3] = segments;
        default: ;
      endcase
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    exp = sb.pop_front();
    check({tag, "_d0"}, 32'(got[0]), 32'(exp[6:0]));
    check({tag, "_d1"}, 32'(got[1]), 32'(exp[13:7]));
    check({tag, "_d2"}, 32'(got[2]), 32'(exp[20:14]));
    check({tag, "_d3"}, 32'(got[3]), 32'(exp[27:21]));
  endtask

  task automatic do_load(input string tag, input logic [7:0] v,
                         input logic h, input logic s);
    int cnt;
    @(negedge clk);
    value = v;
    hex_mode = h;
    signed_mode = s;
    load = 1'b1;
    sb.push_back(model(v, h, s));
    @(negedge clk);
    load = 1'b0;
    value = ~v;
    hex_mode = ~h;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(cnt), h ? 32'd1 : 32'd9);
    scan_compare(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_anodes", 32'(anodes), 32'hFF);
    check("rst_segments", 32'(segments), 32'h7F);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    // Edges 1..16 after release: each digit slot held 4 cycles.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_%0d", k), 32'(anodes),
            32'(8'hFF & ~(8'd1 << ((k - 1) / 4))));
      check($sformatf("scan_seg_%0d", k), 32'(segments),
            ((k - 1) / 4 == 0) ? 32'b0000001 : 32'h7F);
    end

    do_load("u200", 8'd200, 1'b0, 1'b0);
    do_load("sF6", 8'hF6, 1'b0, 1'b1);
    do_load("s80", 8'h80, 1'b0, 1'b1);
    do_load("hA5", 8'hA5, 1'b1, 1'b0);
    do_load("u7", 8'd7, 1'b0, 1'b0);
    do_load("u255", 8'hFF, 1'b0, 1'b0);
    do_load("sFF", 8'hFF, 1'b0, 1'b1);
    do_load("u10", 8'd10, 1'b0, 1'b0);
    do_load("s7F", 8'h7F, 1'b0, 1'b1);
    do_load("h3C", 8'h3C, 1'b1, 1'b1);

    // Load held during conversion with a new value is ignored.
    @(negedge clk);
    value = 8'd200;
    hex_mode = 1'b0;
    signed_mode = 1'b0;
    load = 1'b1;
    sb.push_back(model(8'd200, 1'b0, 1'b0));
    @(negedge clk);
    value = 8'd55;
    hex_mode = 1'b1;
    repeat (4) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    load = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_idle", 32'(busy), 32'd0);
    scan_compare("hold");

    // Reset mid-conversion aborts and restores the '0' display.
    @(negedge clk);
    value = 8'd123;
    hex_mode = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_an", 32'(anodes), 32'hFF);
    reset = 1'b1;
    sb.push_back({7'h7F, 7'h7F, 7'h7F, 7'b0000001});
    repeat (12) @(negedge clk);
    check("mid_after_busy", 32'(busy), 32'd0);
    scan_compare("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
